sram_mem_responder: RTL
=======================

Name: sram_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM stage.
- Accepts single-word 32-bit read and write requests from MEM stage outputs: read enable, write enable, ALU-result address, store value.
- Serves each request from an external 16-bit asynchronous SRAM in two half-word accesses with programmable wait states.
- Drives ready low while busy. Top level ORs ~ready into the freeze path, stalling IF..MEM stage registers until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM half-word 0.
- SRAM_AW, 18: SRAM address width (256K x 16).
- WAIT_CYCLES, 3: cycles per half-word access; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request from MEM stage.
- wr_en  in  1  write request from MEM stage.
- address  in  32  byte address.
- write_data  in  32  store value.
- read_data  out  32  load result; valid while ready=1 in DONE.
- ready  out  1  high = no access in progress, or result/completion this cycle.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_oe  out  1  tri-state enable for sram_dq_out; the top level builds the inout.
- sram_dq_in  in  16  data from SRAM.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. Wait counter cnt (4 bits) clears on every state entry.
- Word index: wi = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits; address[1:0] ignored. Low half-word at {wi,0}, high at {wi,1}. Out-of-range addresses wrap modulo SRAM size; no error is flagged.
- IDLE:
  - wr_en=1 -> WR_LO. Write has priority when rd_en and wr_en are both 1.
  - else rd_en=1 -> RD_LO.
  - else stay.
- RD_LO / RD_HI:
  - sram_addr = {wi,0} / {wi,1}; sram_we_n=1; sram_dq_oe=0.
  - On cnt==WAIT_CYCLES-1: capture sram_dq_in into read_data[15:0] / read_data[31:16], then advance to RD_HI / DONE.
- WR_LO / WR_HI:
  - sram_addr as above; sram_dq_oe=1; sram_dq_out = write_data[15:0] / write_data[31:16].
  - sram_we_n=0 for cnt < WAIT_CYCLES-1, and 1 on the last cycle (data hold).
  - Advance on cnt==WAIT_CYCLES-1 to WR_HI / DONE.
- DONE: one cycle, then always IDLE. sram_we_n=1, sram_dq_oe=0.
- ready (combinational) = (state==IDLE && !rd_en && !wr_en) || state==DONE.
- Latency: a request first seen in IDLE at cycle 0 gets ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 7 for default), for exactly one cycle.
- Back-to-back: a request still asserted when the FSM re-enters IDLE starts a new access. The MEM stage must therefore have advanced on the DONE cycle.
- Request inputs are sampled on every cycle they are used and must be held stable until ready=1.
- Request deasserted mid-access: the access still completes through DONE; the result is discarded by the pipeline.
- Registered outputs (read_data, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe) are updated every cycle from next-state values.
- Reset (including mid-access): next edge gives state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1. A partial SRAM write is abandoned; the strobe is released immediately.

Decomposition:
- Shared package holds:
  - state enum (3-bit encoding, IDLE=0).
  - default BASE_ADDR.
  - SRAM half-word width constant (16).
- One sub-module: sram_wait_counter (clear, tick, last = cnt==WAIT_CYCLES-1). All other logic stays in one module.

Test Plan:
- Idle: rd_en=wr_en=0 for 5 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0 throughout.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF at cycle 0 -> SRAM model holds [0]=0xBEEF and [1]=0xDEAD; sram_we_n low at cycles 1-2 and 4-5; ready=1 only at cycle 7.
- Read-back: rd_en=1, address=1024 -> read_data=0xDEADBEEF and ready=1 at cycle 7; ready=0 at cycles 0-6.
- Addressing: write 0x12345678 to address 1028, then read address 1031 -> half-words 2/3 accessed; read_data=0x12345678.
- Collision: rd_en=wr_en=1, address=1032, write_data=0xA5A5 -> write performed (sram_dq_oe=1); SRAM[4]=0xA5A5.
- Reset: assert rst at cycle 3 of a write -> next cycle state IDLE, sram_we_n=1, sram_dq_oe=0; ready=1 once requests are dropped.

Source files
------------

// File: rtl/sram_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
// The state encoding is fixed at 3 bits with IDLE at zero so that reset lands in IDLE.
package sram_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int          HW_W          = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-state wait-state counter; cleared on every state entry.
// o_pre_last lets the parent predict the counter's next-cycle value for its registered outputs.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_last,
    output logic o_pre_last
);

    localparam logic [3:0] LAST_CNT     = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] PRE_LAST_CNT = 4'(WAIT_CYCLES - 2);

    logic [3:0] r_cnt;

    // Wait counter: clear wins over tick so a state entry always starts at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 4'd0;
        end else if (i_clear) begin
            r_cnt <= 4'd0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_last     = (r_cnt == LAST_CNT);
    assign o_pre_last = (r_cnt == PRE_LAST_CNT);

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage responder serving 32-bit word requests from a 16-bit async SRAM
// as two half-word accesses with programmable wait states.
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HW_W-1:0]    sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [HW_W-1:0]    sram_dq_in,
    output logic               sram_we_n
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_last;
    logic               w_pre_last;
    logic               w_advance;
    logic               w_next_last;
    logic [31:0]        w_off;
    logic [SRAM_AW-2:0] w_wi;

    logic [31:0]        r_read_data;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [HW_W-1:0]    r_sram_dq_out;
    logic               r_sram_dq_oe;
    logic               r_sram_we_n;

    logic [31:0]        w_read_data_next;
    logic [SRAM_AW-1:0] w_addr_next;
    logic [HW_W-1:0]    w_dq_next;
    logic               w_oe_next;
    logic               w_we_n_next;

    // Out-of-range addresses simply wrap: the word index is truncated.
    assign w_off = address - BASE_ADDR;
    assign w_wi  = (SRAM_AW-1)'(w_off >> 2);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_advance),
        .i_tick     (r_state != ST_IDLE),
        .o_last     (w_last),
        .o_pre_last (w_pre_last)
    );

    // Next-state decode; write beats read when both are requested.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (wr_en) begin
                    w_state_next = ST_WR_LO;
                end else if (rd_en) begin
                    w_state_next = ST_RD_LO;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD_LO: w_state_next = w_last ? ST_RD_HI : ST_RD_LO;
            ST_RD_HI: w_state_next = w_last ? ST_DONE  : ST_RD_HI;
            ST_WR_LO: w_state_next = w_last ? ST_WR_HI : ST_WR_LO;
            ST_WR_HI: w_state_next = w_last ? ST_DONE  : ST_WR_HI;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_advance   = (w_state_next != r_state);
    // Next cycle is the data-hold cycle when we stay put and the counter is one short of last.
    assign w_next_last = !w_advance && w_pre_last;

    // Output values for the coming cycle, derived from next state and next count.
    always_comb begin
        w_addr_next      = r_sram_addr;
        w_dq_next        = r_sram_dq_out;
        w_oe_next        = 1'b0;
        w_we_n_next      = 1'b1;
        w_read_data_next = r_read_data;
        case (w_state_next)
            ST_RD_LO: w_addr_next = {w_wi, 1'b0};
            ST_RD_HI: w_addr_next = {w_wi, 1'b1};
            ST_WR_LO: begin
                w_addr_next = {w_wi, 1'b0};
                w_dq_next   = write_data[15:0];
                w_oe_next   = 1'b1;
                w_we_n_next = w_next_last;
            end
            ST_WR_HI: begin
                w_addr_next = {w_wi, 1'b1};
                w_dq_next   = write_data[31:16];
                w_oe_next   = 1'b1;
                w_we_n_next = w_next_last;
            end
            default: begin
                w_addr_next = r_sram_addr;
            end
        endcase
        if (r_state == ST_RD_LO && w_last) begin
            w_read_data_next[15:0] = sram_dq_in;
        end else if (r_state == ST_RD_HI && w_last) begin
            w_read_data_next[31:16] = sram_dq_in;
        end else begin
            w_read_data_next = r_read_data;
        end
    end

    // State and registered SRAM/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_read_data   <= 32'd0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= 16'd0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_read_data   <= w_read_data_next;
            r_sram_addr   <= w_addr_next;
            r_sram_dq_out <= w_dq_next;
            r_sram_dq_oe  <= w_oe_next;
            r_sram_we_n   <= w_we_n_next;
        end
    end

    assign ready       = ((r_state == ST_IDLE) && !rd_en && !wr_en) || (r_state == ST_DONE);
    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_we_n   = r_sram_we_n;

endmodule
